// File: rtl/uart_rx_fifo.sv
// UART receiver with 2-FF input synchroniser, configurable framing and parity,
// false-start rejection, break handling and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
  parameter int unsigned CLOCK_FREQ = 100000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              RX,
  output logic [DATA_BITS-1:0]              RX_DATA,
  output logic                              RX_VALID,
  input  logic                              RX_READY,
  output logic                              FRAME_ERR,
  output logic                              PARITY_ERR,
  output logic                              OVERRUN,
  input  logic                              CLR_ERR,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   FIFO_COUNT,
  output logic                              BUSY
);

  localparam int unsigned BIT_CYCLES = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned HALF       = BIT_CYCLES / 2;
  localparam int unsigned CntW       = $clog2(BIT_CYCLES + 1);
  localparam int unsigned AW         = $clog2(FIFO_DEPTH);
  localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW         = DATA_BITS + 2;
  localparam logic        OddPar     = (PARITY == 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StPar   = 3'd3;
  localparam logic [2:0] StStop  = 3'd4;
  localparam logic [2:0] StBreak = 3'd5;

  logic                 rx_meta_q, rx_s_q;
  logic [2:0]           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 push, bit_end;
  logic [EW-1:0]        entry;

  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [EW-1:0]        mem_d [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overrun_q, overrun_d;
  logic                 pop, full, do_push;
  logic [EW-1:0]        head;

  assign bit_end = (cnt_q == CntW'(BIT_CYCLES - 1));
  // The final stop sample is folded into the pushed entry in the same cycle.
  assign entry   = {perr_q, ferr_q | ~rx_s_q, shift_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push    = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == CntW'(HALF - 1)) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            bit_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? StPar : StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPar: begin
        if (bit_end) begin
          cnt_d   = '0;
          perr_d  = ((^shift_q) ^ rx_s_q) != OddPar;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!rx_s_q) ferr_d = 1'b1;
          if (bit_q == 4'(STOP_BITS - 1)) begin
            push    = 1'b1;
            bit_d   = '0;
            state_d = rx_s_q ? StIdle : StBreak;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBreak: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
  assign pop     = (count_q != '0) && RX_READY;
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign do_push = push && (!full || pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !pop) count_d = count_q + 1'b1;
    else if (!do_push && pop) count_d = count_q - 1'b1;
    if (push && full && !pop) overrun_d = 1'b1;
    else if (CLR_ERR) overrun_d = 1'b0;
    else overrun_d = overrun_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign RX_VALID   = (count_q != '0);
  assign RX_DATA    = RX_VALID ? head[DATA_BITS-1:0] : '0;
  assign FRAME_ERR  = RX_VALID & head[DATA_BITS];
  assign PARITY_ERR = RX_VALID & head[DATA_BITS+1];
  assign OVERRUN    = overrun_q;
  assign FIFO_COUNT = count_q;
  assign BUSY       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 instance (a) and an 8E1 instance (b),
// both at 10 clocks per bit, with a monitor logging every accepted word.
module tb_uart_rx_fifo;

  logic       clk, rst, clr;
  logic       rx_a, ready_a, rx_b, ready_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, ferr_a, perr_a, ovr_a, busy_a;
  logic       valid_b, ferr_b, perr_b, ovr_b, busy_b;
  logic [2:0] count_a, count_b;

  int tests_run    = 0;
  int tests_failed = 0;
  int valid_cycles_a = 0;
  logic [9:0] q_a[$];
  logic [9:0] q_b[$];

  uart_rx_fifo #(
    .CLOCK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut_a (
    .CLK(clk), .RESET(rst), .RX(rx_a), .RX_DATA(data_a), .RX_VALID(valid_a),
    .RX_READY(ready_a), .FRAME_ERR(ferr_a), .PARITY_ERR(perr_a), .OVERRUN(ovr_a),
    .CLR_ERR(clr), .FIFO_COUNT(count_a), .BUSY(busy_a)
  );

  uart_rx_fifo #(
    .CLOCK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut_b (
    .CLK(clk), .RESET(rst), .RX(rx_b), .RX_DATA(data_b), .RX_VALID(valid_b),
    .RX_READY(ready_b), .FRAME_ERR(ferr_b), .PARITY_ERR(perr_b), .OVERRUN(ovr_b),
    .CLR_ERR(clr), .FIFO_COUNT(count_b), .BUSY(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid_a && ready_a) q_a.push_back({perr_a, ferr_a, data_a});
    if (valid_b && ready_b) q_b.push_back({perr_b, ferr_b, data_b});
    if (valid_a) valid_cycles_a++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) rx_b = v;
    else rx_a = v;
    tick(n);
  endtask

  // pop_at_stop raises ready_a for exactly the cycle in which the stop bit is sampled.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                            input logic par, input logic stop, input bit pop_at_stop,
                            input int tail_low);
    drive(sel, 1'b0, 10);
    for (int i = 0; i < 8; i++) drive(sel, d[i], 10);
    if (has_par) drive(sel, par, 10);
    if (pop_at_stop) begin
      rx_a = stop;
      tick(7);
      ready_a = 1'b1;
      tick(1);
      ready_a = 1'b0;
      tick(2);
    end else begin
      drive(sel, stop, 10);
    end
    if (tail_low > 0) drive(sel, 1'b0, tail_low);
    drive(sel, 1'b1, 4);
  endtask

  initial begin
    int waited;
    rst = 1'b1; clr = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    tick(3);
    check("rst_data", data_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_ferr", ferr_a, 0);
    check("rst_perr", perr_a, 0);
    check("rst_ovr", ovr_a, 0);
    check("rst_count", count_a, 0);
    check("rst_busy", busy_a, 0);
    rst = 1'b0;
    tick(2);

    // 8N1 0xA5
    waited = valid_cycles_a;
    send_frame(0, 8'hA5, 0, 1'b0, 1'b1, 0, 0);
    tick(5);
    check("a5_words", q_a.size(), 1);
    check("a5_entry", q_a[0], {2'b00, 8'hA5});
    check("a5_valid_cycles", valid_cycles_a - waited, 1);
    q_a.delete();

    // Even parity: 0x03 has even weight, so parity bit 1 is an error
    send_frame(1, 8'h03, 1, 1'b1, 1'b1, 0, 0);
    tick(5);
    check("par_bad_words", q_b.size(), 1);
    check("par_bad_entry", q_b[0], {2'b10, 8'h03});
    q_b.delete();
    send_frame(1, 8'h03, 1, 1'b0, 1'b1, 0, 0);
    tick(5);
    check("par_ok_words", q_b.size(), 1);
    check("par_ok_entry", q_b[0], {2'b00, 8'h03});
    check("par_b_idle", {busy_b, ovr_b, count_b}, 0);
    q_b.delete();

    // Low stop bit followed by a held break, then a clean frame
    send_frame(0, 8'h55, 0, 1'b0, 1'b0, 0, 50);
    drive(0, 1'b1, 20);
    send_frame(0, 8'h0F, 0, 1'b0, 1'b1, 0, 0);
    tick(5);
    check("brk_words", q_a.size(), 2);
    check("brk_first", q_a[0], {2'b01, 8'h55});
    check("brk_second", q_a[1], {2'b00, 8'h0F});
    q_a.delete();

    // 3-cycle glitch
    drive(0, 1'b0, 3);
    check("glitch_busy_hi", busy_a, 1);
    rx_a = 1'b1;
    waited = 0;
    while (busy_a && waited < 8) begin
      tick(1);
      waited++;
    end
    check("glitch_busy_lo", busy_a, 0);
    tick(20);
    check("glitch_words", q_a.size(), 0);

    // Overrun with consumer stalled
    ready_a = 1'b0;
    for (int b = 1; b <= 5; b++) send_frame(0, 8'(b), 0, 1'b0, 1'b1, 0, 0);
    tick(3);
    check("ovr_count", count_a, 4);
    check("ovr_flag", ovr_a, 1);
    check("ovr_head", data_a, 8'h01);
    ready_a = 1'b1;
    tick(6);
    ready_a = 1'b0;
    check("ovr_drain_words", q_a.size(), 4);
    for (int i = 0; i < 4; i++) check("ovr_drain_order", q_a[i], 10'(i + 1));
    check("ovr_drain_count", count_a, 0);
    check("ovr_sticky", ovr_a, 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("ovr_cleared", ovr_a, 0);
    q_a.delete();

    // Push and pop in the same cycle on a full FIFO
    for (int b = 0; b < 4; b++) send_frame(0, 8'(8'h10 + b), 0, 1'b0, 1'b1, 0, 0);
    check("pp_full", count_a, 4);
    send_frame(0, 8'h14, 0, 1'b0, 1'b1, 1, 0);
    tick(2);
    check("pp_count", count_a, 4);
    check("pp_no_ovr", ovr_a, 0);
    check("pp_popped", q_a.size(), 1);
    check("pp_pop_word", q_a[0], {2'b00, 8'h10});
    check("pp_head", data_a, 8'h11);
    ready_a = 1'b1;
    tick(6);
    ready_a = 1'b0;
    check("pp_drain_words", q_a.size(), 5);
    for (int i = 1; i < 5; i++) check("pp_drain_order", q_a[i], 10'(8'h10 + i));
    q_a.delete();

    // Reset after 4 data bits of 0x3C
    ready_a = 1'b1;
    drive(0, 1'b0, 10);
    drive(0, 1'b0, 10);
    drive(0, 1'b0, 10);
    drive(0, 1'b1, 10);
    drive(0, 1'b1, 10);
    check("mid_busy", busy_a, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_outs", {data_a, valid_a, ferr_a, perr_a, ovr_a, count_a, busy_a}, 0);
    rx_a = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    send_frame(0, 8'h3C, 0, 1'b0, 1'b1, 0, 0);
    tick(5);
    check("post_rst_words", q_a.size(), 1);
    check("post_rst_entry", q_a[0], {2'b00, 8'h3C});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
